// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop at a time, looks up the local line, answers on CR,
// streams the line on CD when data is transferred, then pulses a line-state update.
module ace_snoop_responder #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineBytes = 64,
    localparam int unsigned BeatsRaw = LineBytes * 8 / DataWidth,
    localparam int unsigned Beats    = (BeatsRaw < 1) ? 1 : BeatsRaw,
    localparam int unsigned BeatW    = (Beats > 1) ? $clog2(Beats) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lkp_req_o,
    output logic [AddrWidth-1:0] lkp_addr_o,
    input  logic                 lkp_gnt_i,
    input  logic [2:0]           lkp_state_i,
    output logic                 rd_req_o,
    output logic [BeatW-1:0]     rd_beat_o,
    input  logic [DataWidth-1:0] rd_data_i,
    output logic                 upd_valid_o,
    output logic [AddrWidth-1:0] upd_addr_o,
    output logic [2:0]           upd_state_o
);

    localparam logic [2:0] LineI  = 3'd0;
    localparam logic [2:0] LineSC = 3'd1;
    localparam logic [2:0] LineSD = 3'd2;
    localparam logic [2:0] LineUC = 3'd3;
    localparam logic [2:0] LineUD = 3'd4;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
    localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(LineBytes - 1);

    typedef enum logic [2:0] {StIdle, StLookup, StResp, StRd, StCd, StUpdate} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [3:0]           snoop_q, snoop_d;
    logic [4:0]           resp_q, resp_d;
    logic [2:0]           nst_q, nst_d;
    logic                 upd_q, upd_d;
    logic [BeatW-1:0]     beat_q, beat_d;

    logic       needs_lookup;
    logic       ln_valid, ln_dirty, ln_uniq;
    logic [4:0] dec_resp;
    logic [2:0] dec_nst;
    logic       dec_upd;

    always_comb begin
        needs_lookup = 1'b0;
        case (ac_snoop_i)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0111, 4'b1000, 4'b1001, 4'b1101: needs_lookup = 1'b1;
            default:                            needs_lookup = 1'b0;
        endcase
    end

    // Response bits: {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
    always_comb begin
        ln_valid = (lkp_state_i != LineI);
        ln_dirty = (lkp_state_i == LineSD) || (lkp_state_i == LineUD);
        ln_uniq  = (lkp_state_i == LineUC) || (lkp_state_i == LineUD);
        dec_resp = 5'b00000;
        dec_nst  = lkp_state_i;
        if (ln_valid) begin
            case (snoop_q)
                4'b0000: dec_resp = {ln_uniq, 1'b1, 1'b0, 1'b0, 1'b1};
                4'b0001, 4'b0010, 4'b0011: begin
                    dec_resp = {ln_uniq, 1'b1, ln_dirty, 1'b0, 1'b1};
                    dec_nst  = LineSC;
                end
                4'b0111: begin
                    dec_resp = {ln_uniq, 1'b0, ln_dirty, 1'b0, 1'b1};
                    dec_nst  = LineI;
                end
                4'b1001: begin
                    dec_resp = {ln_uniq, 1'b0, ln_dirty, 1'b0, ln_dirty};
                    dec_nst  = LineI;
                end
                4'b1000: begin
                    dec_resp = {1'b0, 1'b1, ln_dirty, 1'b0, ln_dirty};
                    if (lkp_state_i == LineSD) dec_nst = LineSC;
                    if (lkp_state_i == LineUD) dec_nst = LineUC;
                end
                4'b1101: dec_nst = LineI;
                default: dec_nst = lkp_state_i;
            endcase
        end
        dec_upd = ln_valid && (dec_nst != lkp_state_i);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        snoop_d = snoop_q;
        resp_d  = resp_q;
        nst_d   = nst_q;
        upd_d   = upd_q;
        beat_d  = beat_q;
        case (state_q)
            StIdle: begin
                if (ac_valid_i) begin
                    addr_d  = ac_addr_i & ~OffMask;
                    snoop_d = ac_snoop_i;
                    beat_d  = '0;
                    if (needs_lookup) begin
                        state_d = StLookup;
                    end else begin
                        resp_d  = 5'b00000;
                        upd_d   = 1'b0;
                        state_d = StResp;
                    end
                end
            end
            StLookup: begin
                if (lkp_gnt_i) begin
                    resp_d  = dec_resp;
                    nst_d   = dec_nst;
                    upd_d   = dec_upd;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (cr_ready_i) begin
                    if (resp_q[0])  state_d = StRd;
                    else if (upd_q) state_d = StUpdate;
                    else            state_d = StIdle;
                end
            end
            StRd: state_d = StCd;
            StCd: begin
                if (cd_ready_i) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = upd_q ? StUpdate : StIdle;
                    end else begin
                        beat_d  = beat_q + BeatW'(1);
                        state_d = StRd;
                    end
                end
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            snoop_q <= '0;
            resp_q  <= '0;
            nst_q   <= LineI;
            upd_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            snoop_q <= snoop_d;
            resp_q  <= resp_d;
            nst_q   <= nst_d;
            upd_q   <= upd_d;
            beat_q  <= beat_d;
        end
    end

    // All valids decode from registered state only; ac_ready_o is also masked during reset.
    assign ac_ready_o  = (state_q == StIdle) && !rst_i;
    assign lkp_req_o   = (state_q == StLookup);
    assign lkp_addr_o  = addr_q;
    assign cr_valid_o  = (state_q == StResp);
    assign cr_resp_o   = resp_q;
    assign rd_req_o    = (state_q == StRd);
    assign rd_beat_o   = beat_q;
    assign cd_valid_o  = (state_q == StCd);
    assign cd_data_o   = rd_data_i;
    assign cd_last_o   = (beat_q == LastBeat);
    assign upd_valid_o = (state_q == StUpdate);
    assign upd_addr_o  = addr_q;
    assign upd_state_o = nst_q;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: an abstract snoop-rule model plus a per-cycle
// output monitor, driven by directed snoop vectors.
module tb_ace_snoop_responder;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LB = 64;
    localparam int BEATS = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          ac_valid_i = 1'b0;
    logic          ac_ready_o;
    logic [AW-1:0] ac_addr_i = '0;
    logic [3:0]    ac_snoop_i = '0;
    logic          cr_valid_o;
    logic          cr_ready_i = 1'b0;
    logic [4:0]    cr_resp_o;
    logic          cd_valid_o;
    logic          cd_ready_i = 1'b0;
    logic [DW-1:0] cd_data_o;
    logic          cd_last_o;
    logic          lkp_req_o;
    logic [AW-1:0] lkp_addr_o;
    logic          lkp_gnt_i;
    logic [2:0]    lkp_state_i;
    logic          rd_req_o;
    logic [2:0]    rd_beat_o;
    logic [DW-1:0] rd_data_i = '0;
    logic          upd_valid_o;
    logic [AW-1:0] upd_addr_o;
    logic [2:0]    upd_state_o;

    ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineBytes(LB)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
        .cd_last_o(cd_last_o),
        .lkp_req_o(lkp_req_o), .lkp_addr_o(lkp_addr_o), .lkp_gnt_i(lkp_gnt_i),
        .lkp_state_i(lkp_state_i),
        .rd_req_o(rd_req_o), .rd_beat_o(rd_beat_o), .rd_data_i(rd_data_i),
        .upd_valid_o(upd_valid_o), .upd_addr_o(upd_addr_o), .upd_state_o(upd_state_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_data(input logic [63:0] addr, input int beat);
        return {addr[31:0], 32'hC0DE_0000 | 32'(beat)};
    endfunction

    // Snoop rules written as per-field membership sets rather than a per-code decode.
    function automatic void model(input logic [3:0] code, input logic [2:0] st,
                                  output bit lk, output logic [4:0] resp,
                                  output bit upd, output logic [2:0] nst);
        bit v, d, u, wu, is, pd, dt;
        int c;
        c  = int'(code);
        v  = (st != 3'd0);
        d  = (st == 3'd2) || (st == 3'd4);
        u  = (st == 3'd3) || (st == 3'd4);
        lk = c inside {0, 1, 2, 3, 7, 8, 9, 13};
        wu = u && (c inside {0, 1, 2, 3, 7, 9});
        is = c inside {0, 1, 2, 3, 8};
        pd = d && (c inside {1, 2, 3, 7, 8, 9});
        dt = (c inside {0, 1, 2, 3, 7}) || (d && (c inside {8, 9}));
        nst = st;
        if (c inside {1, 2, 3}) nst = 3'd1;
        if (c inside {7, 9, 13}) nst = 3'd0;
        if (c == 8 && st == 3'd2) nst = 3'd1;
        if (c == 8 && st == 3'd4) nst = 3'd3;
        resp = {wu, is, pd, 1'b0, dt};
        if (!v || !lk) begin
            resp = 5'b00000;
            nst  = st;
        end
        upd = v && lk && (nst != st);
    endfunction

    // Environment knobs and expectations for the current snoop.
    logic [2:0]  line_st = 3'd0;
    int          gnt_delay = 0, cr_hold = 0;
    bit          cd_rand = 0;
    logic [63:0] exp_addr = '0;
    logic [4:0]  exp_resp = '0;
    logic [2:0]  exp_nst = '0;
    // Observations for the current snoop.
    int          cyc = 0, t_ac = 0, cr_lat = -1;
    int          lk_cycles = 0, cr_hs = 0, beat_idx = 0, upd_seen = 0;
    logic [4:0]  got_resp = '0;
    logic [2:0]  got_upd_st = '0;
    logic [63:0] got_lkp_addr = '0;
    int          ret_lat = 0;

    int req_cnt = 0, cr_wait = 0;
    assign lkp_state_i = line_st;
    assign lkp_gnt_i   = lkp_req_o && (req_cnt > gnt_delay);

    // Environment: data array, grant delay and ready generation.
    initial begin
        bit pend_rd;
        int pend_beat;
        forever begin
            @(negedge clk);
            pend_rd   = rd_req_o;
            pend_beat = int'(rd_beat_o);
            @(posedge clk);
            cyc++;
            #1;
            if (pend_rd) rd_data_i = mk_data(exp_addr, pend_beat);
            if (lkp_req_o) req_cnt++;
            else req_cnt = 0;
            if (cr_valid_o) begin
                cr_ready_i = (cr_wait >= cr_hold);
                cr_wait++;
            end else begin
                cr_wait    = 0;
                cr_ready_i = 1'b0;
            end
            cd_ready_i = cd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle compare against the model expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (ac_valid_i && ac_ready_o) t_ac = cyc;
            if (lkp_req_o) begin
                lk_cycles++;
                got_lkp_addr = lkp_addr_o;
                check("lkp_addr", lkp_addr_o, exp_addr);
            end
            if (cr_valid_o) begin
                if (cr_lat < 0) cr_lat = cyc - t_ac;
                got_resp = cr_resp_o;
                check("cr_resp", 64'(cr_resp_o), 64'(exp_resp));
                if (cr_ready_i) cr_hs++;
            end
            if (cd_valid_o) begin
                check("cd_after_cr", 64'(cr_hs), 64'd1);
                check("cd_data", cd_data_o, mk_data(exp_addr, beat_idx));
                check("cd_last", 64'(cd_last_o), 64'(beat_idx == BEATS - 1));
                if (cd_ready_i) beat_idx++;
            end
            if (upd_valid_o) begin
                upd_seen++;
                got_upd_st = upd_state_o;
                check("upd_addr", upd_addr_o, exp_addr);
                check("upd_state", 64'(upd_state_o), 64'(exp_nst));
            end
        end
    end

    task automatic issue(input logic [63:0] addr, input logic [3:0] code, input logic [2:0] st,
                         input int gdly, input int crh, input bit rnd,
                         output bit lk, output bit upd);
        logic [4:0] resp;
        logic [2:0] nst;
        int n;
        model(code, st, lk, resp, upd, nst);
        exp_addr  = addr & ~64'(LB - 1);
        exp_resp  = resp;
        exp_nst   = nst;
        line_st   = st;
        gnt_delay = gdly;
        cr_hold   = crh;
        cd_rand   = rnd;
        lk_cycles = 0; cr_hs = 0; beat_idx = 0; upd_seen = 0; cr_lat = -1;
        @(posedge clk);
        #1;
        ac_valid_i = 1'b1;
        ac_addr_i  = addr;
        ac_snoop_i = code;
        n = 0;
        @(negedge clk);
        while (!ac_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("ac_accept", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        ac_valid_i = 1'b0;
    endtask

    task automatic run_snoop(input logic [63:0] addr, input logic [3:0] code,
                             input logic [2:0] st, input int gdly, input int crh, input bit rnd);
        bit lk, upd;
        int n;
        issue(addr, code, st, gdly, crh, rnd, lk, upd);
        n = 0;
        @(negedge clk);
        while (!ac_ready_o && n < 500) begin
            n++;
            @(negedge clk);
        end
        ret_lat = cyc - t_ac;
        check("done_in_budget", 64'(n < 500), 64'd1);
        check("cr_handshakes", 64'(cr_hs), 64'd1);
        check("cd_beats", 64'(beat_idx), exp_resp[0] ? 64'(BEATS) : 64'd0);
        check("upd_pulses", 64'(upd_seen), 64'(upd));
        check("lkp_cycles", 64'(lk_cycles), lk ? 64'(gdly + 1) : 64'd0);
        check("cr_latency", 64'(cr_lat), lk ? 64'(gdly + 2) : 64'd1);
    endtask

    task automatic check_quiet(input string name, input logic exp_ready);
        check(name, 64'({cr_valid_o, cd_valid_o, rd_req_o, lkp_req_o, upd_valid_o, ac_ready_o}),
              64'({5'b00000, exp_ready}));
    endtask

    initial begin
        bit lk, upd;
        int n, upd_before;
        // Power-on reset, 3 cycles.
        @(negedge clk);
        check("rst_ac_ready_low", 64'(ac_ready_o), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check_quiet("rst_quiet", 1'b0);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_quiet("post_rst_idle", 1'b1);

        // ReadShared on UD, immediate grant.
        run_snoop(64'h1040, 4'b0001, 3'd4, 0, 0, 0);
        check("rs_ud_resp", 64'(got_resp), 64'(5'b11101));
        check("rs_ud_upd_sc", 64'(got_upd_st), 64'd1);
        check("rs_ud_lkp_addr", got_lkp_addr, 64'h1040);

        // ReadUnique on an invalid line: no data, no update, quick return.
        run_snoop(64'h2000, 4'b0111, 3'd0, 0, 0, 0);
        check("ru_i_resp", 64'(got_resp), 64'd0);
        check("ru_i_ready_back", 64'(ret_lat <= 4), 64'd1);

        // CleanShared on UC then UD.
        run_snoop(64'h3000, 4'b1000, 3'd3, 0, 0, 0);
        check("cs_uc_resp", 64'(got_resp), 64'(5'b01000));
        run_snoop(64'h3040, 4'b1000, 3'd4, 0, 0, 0);
        check("cs_ud_resp", 64'(got_resp), 64'(5'b01101));
        check("cs_ud_upd_uc", 64'(got_upd_st), 64'd3);

        // Backpressure on CR and CD.
        run_snoop(64'h4080, 4'b0111, 3'd2, 0, 5, 1);
        check("ru_sd_resp", 64'(got_resp), 64'(5'b00101));
        run_snoop(64'h40C0, 4'b0010, 3'd1, 2, 5, 1);

        // DVM: no lookup, zero response one cycle after AC.
        run_snoop(64'h5000, 4'b1111, 3'd4, 0, 0, 0);
        check("dvm_resp", 64'(got_resp), 64'd0);

        // Delayed grant.
        run_snoop(64'h6000, 4'b0000, 3'd1, 4, 0, 0);
        check("ro_sc_resp", 64'(got_resp), 64'(5'b01001));

        // Unaligned address, MakeInvalid, CleanInvalid, ReadNotSharedDirty.
        run_snoop(64'h0002_0013, 4'b1101, 3'd3, 1, 1, 0);
        check("mi_upd_addr_aligned", got_lkp_addr, 64'h0002_0000);
        check("mi_upd_i", 64'(got_upd_st), 64'd0);
        run_snoop(64'h7000, 4'b1001, 3'd3, 0, 0, 0);
        check("ci_uc_resp", 64'(got_resp), 64'(5'b10000));
        run_snoop(64'h7040, 4'b1001, 3'd4, 0, 0, 1);
        check("ci_ud_resp", 64'(got_resp), 64'(5'b10101));
        run_snoop(64'h8000, 4'b0011, 3'd2, 0, 2, 1);

        // Reset in the middle of the CD stream.
        issue(64'h9000, 4'b0001, 3'd4, 0, 0, 1, lk, upd);
        n = 0;
        @(negedge clk);
        while (!(cd_valid_o && beat_idx >= 3) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("reached_mid_cd", 64'(n < 200), 64'd1);
        upd_before = upd_seen;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        check("mid_rst_ac_ready_low", 64'(ac_ready_o), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check_quiet("mid_rst_quiet", 1'b0);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_quiet("mid_rst_release", 1'b1);
        repeat (20) @(negedge clk);
        check("abort_no_upd", 64'(upd_seen), 64'(upd_before));

        // A normal snoop still completes after the abort.
        run_snoop(64'hA000, 4'b0001, 3'd2, 0, 0, 0);
        check("post_abort_resp", 64'(got_resp), 64'(5'b01101));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
